// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
//   Two-stage valid/ready pipeline that evaluates CHANNELS independent
//   N_IN-input gates per beat. The gate function (NAND/NOR/AND/OR/XOR/XNOR)
//   is chosen at run time through a small config port and is captured with
//   each beat, so later mode changes never affect beats already in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   cfg_we     mode write strobe
//   cfg_mode   requested mode (0 NAND,1 NOR,2 AND,3 OR,4 XOR,5 XNOR)
//   cfg_err    sticky flag: a write of mode 6/7 was attempted
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   in_data    channel c uses bits [c*N_IN +: N_IN]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   bit c = gate result of channel c
//   out_mode   mode used to compute this result
//   xfer_count results delivered (out_valid && out_ready), wraps silently
module logic_gate_pipe #(
  parameter int N_IN     = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_mode,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*N_IN-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS-1:0]        out_data,
  output logic [2:0]                 out_mode,
  output logic [CNT_W-1:0]           xfer_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic gate_reduce(input logic [N_IN-1:0] bits,
                                       input logic [2:0]      mode);
    logic r;
    case (mode)
      3'd0:    r = ~(&bits);
      3'd1:    r = ~(|bits);
      3'd2:    r = &bits;
      3'd3:    r = |bits;
      3'd4:    r = ^bits;
      3'd5:    r = ~(^bits);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [2:0]               mode_act;
  logic [CNT_W-1:0]         cnt;
  logic                     vld_p1;
  logic                     vld_p2;
  logic [CHANNELS*N_IN-1:0] data_p1;
  logic [2:0]               mode_p1;
  logic [CHANNELS-1:0]      res_p1;
  logic [CHANNELS-1:0]      data_p2;
  logic [2:0]               mode_p2;
  logic                     adv_p2;
  logic                     accept;
  logic                     deliver;

  // Handshake: in_ready depends only on registered state and out_ready.
  assign adv_p2   = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready = !vld_p1 || adv_p2;
  assign accept   = in_valid && in_ready;
  assign deliver  = vld_p2 && out_ready;

  // Control: active mode, sticky error, stage valids, delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_act <= 3'd0;
      cfg_err  <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (cfg_we) begin
        if (cfg_mode <= 3'd5) mode_act <= cfg_mode;
        else                  cfg_err  <= 1'b1;
      end
      if (accept)      vld_p1 <= 1'b1;
      else if (adv_p2) vld_p1 <= 1'b0;
      if (adv_p2)      vld_p2 <= 1'b1;
      else if (deliver) vld_p2 <= 1'b0;
      if (deliver) cnt <= cnt + CNT_ONE;
    end
  end

  // ---- stage p1: capture raw beat with the mode active at accept time ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= in_data;
      mode_p1 <= mode_act;
    end
  end

  always_comb begin
    res_p1 = '0;
    for (int c = 0; c < CHANNELS; c++)
      res_p1[c] = gate_reduce(data_p1[c*N_IN +: N_IN], mode_p1);
  end

  // ---- stage p2: reduced result, held while downstream stalls ----
  // Cleared on reset so the output bus reads zero before the first result.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2 <= '0;
      mode_p2 <= 3'd0;
    end else if (adv_p2) begin
      data_p2 <= res_p1;
      mode_p2 <= mode_p1;
    end
  end

  assign out_valid  = vld_p2;
  assign out_data   = data_p2;
  assign out_mode   = mode_p2;
  assign xfer_count = cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Testbench for logic_gate_pipe: directed scenario tasks plus a negedge
// reference model (queue of expected results with accept timestamps) that
// checks every cycle. A second instance with CNT_W=2 shares all inputs to
// exercise counter wrap.
module tb_logic_gate_pipe;

  localparam int N_IN = 2;
  localparam int CH   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_mode = 3'd0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_ready = 1'b1;

  logic          cfg_err, in_ready, out_valid;
  logic [3:0]    out_data;
  logic [2:0]    out_mode;
  logic [7:0]    xfer_count;

  logic          cfg_err2, in_ready2, out_valid2;
  logic [3:0]    out_data2;
  logic [2:0]    out_mode2;
  logic [1:0]    xfer_count2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  logic_gate_pipe #(.N_IN(N_IN), .CHANNELS(CH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .xfer_count(xfer_count));

  logic_gate_pipe #(.N_IN(N_IN), .CHANNELS(CH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_err(cfg_err2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_mode(out_mode2), .xfer_count(xfer_count2));

  // Reference: count the ones in each channel and apply the gate's rule.
  function automatic logic [3:0] ref_result(input logic [7:0] d, input logic [2:0] m);
    logic [3:0] r;
    int ones;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      ones = 0;
      for (int b = 0; b < N_IN; b++) ones += int'(d[c*N_IN + b]);
      case (m)
        3'd0: r[c] = (ones != N_IN);
        3'd1: r[c] = (ones == 0);
        3'd2: r[c] = (ones == N_IN);
        3'd3: r[c] = (ones != 0);
        3'd4: r[c] = (ones % 2 == 1);
        3'd5: r[c] = (ones % 2 == 0);
        default: r[c] = 1'b0;
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [3:0] res;
    logic [2:0] mode;
    int         acc;
  } beat_t;

  beat_t       q[$];
  logic [2:0]  mode_m = 3'd0;
  logic        err_m = 1'b0;
  int          cnt_m = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          exp_rdy, exp_vld;

  // Sampled mid-cycle; describes the state seen by the coming posedge.
  always @(negedge clk) begin
    exp_rdy = (q.size() < 2) || out_ready;
    exp_vld = (q.size() > 0) && (q[0].acc + 2 <= cyc);
    if (mon_en) begin
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL mon_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_rdy);
      end
      vectors++;
      if (out_valid !== exp_vld) begin
        miscompares++;
        $display("FAIL mon_out_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_vld);
      end
      if (exp_vld) begin
        vectors++;
        if (out_data !== q[0].res || out_mode !== q[0].mode) begin
          miscompares++;
          $display("FAIL mon_result cyc=%0d got data=%b mode=%0d exp data=%b mode=%0d",
                   cyc, out_data, out_mode, q[0].res, q[0].mode);
        end
      end
      vectors++;
      if (cfg_err !== err_m) begin
        miscompares++;
        $display("FAIL mon_cfg_err cyc=%0d got %b exp %b", cyc, cfg_err, err_m);
      end
      vectors++;
      if (xfer_count !== 8'(cnt_m) || xfer_count2 !== 2'(cnt_m)) begin
        miscompares++;
        $display("FAIL mon_xfer_count cyc=%0d got %0d/%0d exp %0d/%0d",
                 cyc, xfer_count, xfer_count2, 8'(cnt_m), 2'(cnt_m));
      end
    end
    if (rst) begin
      q.delete();
      mode_m = 3'd0;
      err_m  = 1'b0;
      cnt_m  = 0;
      mon_en = 1;
    end else begin
      if (exp_vld && out_ready) begin
        void'(q.pop_front());
        cnt_m++;
      end
      if (in_valid && exp_rdy)
        q.push_back('{res: ref_result(in_data, mode_m), mode: mode_m, acc: cyc});
      if (cfg_we) begin
        if (cfg_mode <= 3'd5) mode_m = cfg_mode;
        else                  err_m  = 1'b1;
      end
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_handshake got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    vectors++;
    if (out_data !== 4'b0 || out_mode !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got data=%b mode=%0d exp 0/0", out_data, out_mode);
    end
    vectors++;
    if (xfer_count !== 8'd0 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_count_err got cnt=%0d err=%b exp 0/0", xfer_count, cfg_err);
    end
  endtask

  task automatic test_nand;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'b11_10_01_00;
    tick;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL nand_early_valid got %b exp 0", out_valid);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 4'b0111 || out_mode !== 3'd0) begin
      miscompares++;
      $display("FAIL nand_result got v=%b data=%b mode=%0d exp v=1 data=0111 mode=0",
               out_valid, out_data, out_mode);
    end
    tick;
    vectors++;
    if (xfer_count !== 8'd1) begin
      miscompares++;
      $display("FAIL nand_xfer_count got %0d exp 1", xfer_count);
    end
  endtask

  task automatic test_modes;
    logic [3:0] exp_tab [4];
    exp_tab = '{4'b0001, 4'b1000, 4'b1110, 4'b0110};
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_mode = 3'd1; in_valid = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_data = 8'b11_10_01_00;
        cfg_we = (i < 3); cfg_mode = 3'(i + 2);
      end else begin
        in_valid = 1'b0; cfg_we = 1'b0;
      end
      tick;
      if (i >= 1 && i <= 4) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_tab[i-1] || out_mode !== 3'(i)) begin
          miscompares++;
          $display("FAIL modes_beat%0d got v=%b data=%b mode=%0d exp v=1 data=%b mode=%0d",
                   i - 1, out_valid, out_data, out_mode, exp_tab[i-1], i);
        end
      end
    end
  endtask

  task automatic test_same_cycle;
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_mode = 3'd0; in_valid = 1'b0;
    tick;
    cfg_mode = 3'd5; in_valid = 1'b1; in_data = 8'($urandom);
    tick;
    cfg_we = 1'b0; in_data = 8'($urandom);
    tick;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_mode !== 3'd0) begin
      miscompares++;
      $display("FAIL same_cycle_old got v=%b mode=%0d exp v=1 mode=0", out_valid, out_mode);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b1 || out_mode !== 3'd5) begin
      miscompares++;
      $display("FAIL same_cycle_new got v=%b mode=%0d exp v=1 mode=5", out_valid, out_mode);
    end
    tick;
  endtask

  task automatic test_stall;
    int acc, n;
    bit have;
    logic [3:0] first;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick;
    out_ready = 1'b0; acc = 0; have = 0; first = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      #2;
      if (in_ready) acc++;
      tick;
      if (out_valid) begin
        if (!have) begin
          first = out_data; have = 1;
        end else begin
          vectors++;
          if (out_data !== first) begin
            miscompares++;
            $display("FAIL stall_hold got %b exp %b", out_data, first);
          end
        end
      end
    end
    vectors++;
    if (acc != 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_accepts got acc=%0d in_ready=%b exp acc=2 in_ready=0", acc, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    for (int k = 0; k < 10 && out_valid; k++) begin
      tick;
      n++;
    end
    vectors++;
    if (n != 2 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain got n=%0d v=%b exp n=2 v=0", n, out_valid);
    end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_mode = 3'd2;
    tick;
    cfg_mode = 3'd7;
    tick;
    cfg_we = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_err_set got %b exp 1", cfg_err);
    end
    in_valid = 1'b1; in_data = 8'b11_10_01_00;
    tick;
    in_valid = 1'b0;
    tick;
    vectors++;
    if (out_valid !== 1'b1 || out_mode !== 3'd2 || out_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL illegal_mode_kept got v=%b data=%b mode=%0d exp v=1 data=1000 mode=2",
               out_valid, out_data, out_mode);
    end
    cfg_we = 1'b1; cfg_mode = 3'd3;
    tick;
    cfg_we = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_err_sticky got %b exp 1", cfg_err);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_err_clear got %b exp 0", cfg_err);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1;
    tick;
    rst = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      in_valid = (j < 5); in_data = 8'($urandom);
      tick;
      if (j >= 2) begin
        vectors++;
        if (xfer_count2 !== exp_cnt[j-2]) begin
          miscompares++;
          $display("FAIL wrap_count step%0d got %0d exp %0d", j - 2, xfer_count2, exp_cnt[j-2]);
        end
      end
    end
    in_valid = 1'b1; in_data = 8'($urandom);
    tick;
    in_data = 8'($urandom);
    tick;
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || xfer_count !== 8'd0 || xfer_count2 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_inflight got v=%b cnt=%0d cnt2=%0d exp 0/0/0",
               out_valid, xfer_count, xfer_count2);
    end
    tick; tick;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ghost got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      cfg_we    = ($urandom % 8) == 0;
      cfg_mode  = 3'($urandom % 8);
      in_data   = 8'($urandom);
      rst       = ($urandom % 97) == 0;
      tick;
    end
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick;
    vectors++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain got v=%b pending=%0d exp v=0 pending=0", out_valid, q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_nand;
    test_modes;
    test_same_cycle;
    test_stall;
    test_illegal;
    test_wrap;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
